lsu_mem_access: RTL

- Memory-access stage directly downstream of the decode/control generator.
- Consumes mem_op, mem_wen and mem_ren plus the ALU-computed address and the rs2 store data.
- Runs one load or store per request over a valid/ready data-memory bus, aligns write data and byte strobes, and extracts and sign/zero-extends load data.
- Stalls the core via busy until the access completes; reports misalignment and bus errors/timeouts.

---
 rtl/lsu_mem_access_pkg.sv | 45 ++++
 rtl/lsu_mem_access_align.sv | 58 +++++
 rtl/lsu_mem_access.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared types and encodings for the load/store memory-access stage.
package lsu_mem_access_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_RESP = 2'd2,
    LSU_ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] MEM_CTRL_LB  = 3'b000;
  localparam logic [2:0] MEM_CTRL_LH  = 3'b001;
  localparam logic [2:0] MEM_CTRL_LW  = 3'b010;
  localparam logic [2:0] MEM_CTRL_LBU = 3'b100;
  localparam logic [2:0] MEM_CTRL_LHU = 3'b101;
  localparam logic [2:0] MEM_CTRL_SB  = MEM_CTRL_LB;
  localparam logic [2:0] MEM_CTRL_SH  = MEM_CTRL_LH;
  localparam logic [2:0] MEM_CTRL_SW  = MEM_CTRL_LW;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Store-side lane payload produced by the aligner.
  typedef struct packed {
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] wdata;
    logic              misalign;
  } st_lane_t;

  // Access size for a func3 code; unknown codes behave as a word.
  function automatic mem_size_e mem_size(input logic [2:0] op);
    case (op)
      MEM_CTRL_LB, MEM_CTRL_LBU: mem_size = SZ_B;
      MEM_CTRL_LH, MEM_CTRL_LHU: mem_size = SZ_H;
      MEM_CTRL_LW:               mem_size = SZ_W;
      default:                   mem_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_access_align.sv
// Combinational lane steering: store strobes/data/misalign and load extraction/extension.
module lsu_mem_access_align
  import lsu_mem_access_pkg::*;
(
  input  logic [2:0]        st_op,
  input  logic [1:0]        st_lane,
  input  logic [DATA_W-1:0] st_data,
  output st_lane_t          st,
  input  logic [2:0]        ld_op,
  input  logic [1:0]        ld_lane,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_shift;
  logic              ld_signed;

  // Store direction; misalignment is judged on size alone, so loads reuse it.
  always_comb begin : store_lanes
    st = '0;
    case (st_op)
      MEM_CTRL_SB, MEM_CTRL_LBU: begin
        st.wstrb    = 4'b0001 << st_lane;
        st.wdata    = {4{st_data[7:0]}};
        st.misalign = 1'b0;
      end
      MEM_CTRL_SH, MEM_CTRL_LHU: begin
        st.wstrb    = 4'b0011 << st_lane;
        st.wdata    = {2{st_data[15:0]}};
        st.misalign = st_lane[0];
      end
      MEM_CTRL_SW: begin
        st.wstrb    = 4'b1111;
        st.wdata    = st_data;
        st.misalign = |st_lane;
      end
      default: begin
        st.wstrb    = 4'b1111;
        st.wdata    = st_data;
        st.misalign = |st_lane;
      end
    endcase
  end

  // Load direction: bring the addressed lane down to bit 0, then extend.
  always_comb begin : load_extract
    ld_shift  = ld_word >> {ld_lane, 3'b000};
    ld_signed = (ld_op == MEM_CTRL_LB) || (ld_op == MEM_CTRL_LH);
    case (mem_size(ld_op))
      SZ_B:    ld_data = ld_signed ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                   : {24'b0, ld_shift[7:0]};
      SZ_H:    ld_data = ld_signed ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                   : {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage: one load/store per start over a valid/ready bus, with
// misalign detection, bus-error/timeout reporting and a busy stall.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mem_op,
  input  logic              mem_wen,
  input  logic              mem_ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err_misalign,
  output logic              err_bus,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_wen,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_rsp_valid,
  output logic              bus_rsp_ready,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              store_q, store_d;
  logic              busy_d, done_d, err_mis_d, err_bus_d;
  logic              req_valid_d, rsp_ready_d, req_wen_d;
  logic [DATA_W-1:0] rdata_d, req_wdata_d, ld_data;
  logic [ADDR_W-1:0] req_addr_d;
  logic [3:0]        req_wstrb_d;
  logic              timeout_hit;
  st_lane_t          st;

  lsu_mem_access_align u_align (
    .st_op   (mem_op),
    .st_lane (addr[1:0]),
    .st_data (wdata),
    .st      (st),
    .ld_op   (op_q),
    .ld_lane (lane_q),
    .ld_word (bus_rsp_rdata),
    .ld_data (ld_data)
  );

  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q       <= LSU_ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      store_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_misalign  <= 1'b0;
      err_bus       <= 1'b0;
      rdata         <= '0;
      bus_req_valid <= 1'b0;
      bus_rsp_ready <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wen   <= 1'b0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      store_q       <= store_d;
      busy          <= busy_d;
      done          <= done_d;
      err_misalign  <= err_mis_d;
      err_bus       <= err_bus_d;
      rdata         <= rdata_d;
      bus_req_valid <= req_valid_d;
      bus_rsp_ready <= rsp_ready_d;
      bus_req_addr  <= req_addr_d;
      bus_req_wen   <= req_wen_d;
      bus_req_wdata <= req_wdata_d;
      bus_req_wstrb <= req_wstrb_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin : next_logic
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    store_d     = store_q;
    err_mis_d   = 1'b0;
    err_bus_d   = 1'b0;
    rdata_d     = rdata;
    req_addr_d  = bus_req_addr;
    req_wen_d   = bus_req_wen;
    req_wdata_d = bus_req_wdata;
    req_wstrb_d = bus_req_wstrb;

    case (state_q)
      LSU_ST_IDLE: begin
        if (start && (mem_wen || mem_ren)) begin
          op_d        = mem_op;
          lane_d      = addr[1:0];
          store_d     = mem_wen;
          req_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          req_wen_d   = mem_wen;
          req_wdata_d = mem_wen ? st.wdata : '0;
          req_wstrb_d = mem_wen ? st.wstrb : 4'b0000;
          if (st.misalign) begin
            state_d   = LSU_ST_DONE;
            err_mis_d = 1'b1;
          end else begin
            state_d = LSU_ST_REQ;
          end
        end
      end
      LSU_ST_REQ: begin
        if (bus_req_valid && bus_req_ready) begin
          state_d = LSU_ST_RESP;
        end else if (timeout_hit) begin
          state_d   = LSU_ST_DONE;
          err_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_ST_RESP: begin
        if (bus_rsp_valid) begin
          state_d   = LSU_ST_DONE;
          err_bus_d = bus_rsp_err;
          if (!store_q && !bus_rsp_err) rdata_d = ld_data;
        end else if (timeout_hit) begin
          state_d   = LSU_ST_DONE;
          err_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_ST_DONE: state_d = LSU_ST_IDLE;
      default:     state_d = LSU_ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    busy_d      = (state_d != LSU_ST_IDLE);
    done_d      = (state_d == LSU_ST_DONE);
    req_valid_d = (state_d == LSU_ST_REQ);
    rsp_ready_d = (state_d == LSU_ST_RESP);
  end

endmodule
